mem_stage: RTL

Memory-access pipeline stage of the rv32 core, directly downstream of the execute stage. Consumes `ex_mem_pipeline_reg_t`, performs loads and stores over a req/gnt/rvalid data-memory port, aligns store data and load results, and registers `mem_wb_pipeline_reg_t` for writeback. Generates the pipeline stall for multi-cycle accesses and supplies the MEM-stage forwarding value to execute.

---
 rtl/rv32_pkg.sv | 38 +++
 rtl/mem_align.sv | 42 ++++
 rtl/mem_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 core types used by the MEM stage: pipeline register layouts,
// access-size encoding and the memory-access FSM states.
package rv32_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        mem_unsigned;
  } ex_mem_pipeline_reg_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        valid;
  } mem_wb_pipeline_reg_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store byte enables and replicated write data,
// misalignment detection, and load extraction with sign/zero extension.
module mem_align
  import rv32_pkg::*;
(
  input  logic [1:0]  off_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = rs2_i;
    misaligned_o = 1'b0;
    load_data_o  = rdata_i;
    case (size_i)
      MEM_B: begin
        be_o        = 4'b0001 << off_i;
        wdata_o     = {4{rs2_i[7:0]}};
        load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be_o         = 4'b0011 << off_i;
        wdata_o      = {2{rs2_i[15:0]}};
        misaligned_o = off_i[0];
        load_data_o  = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      default: misaligned_o = |off_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the req/gnt/rvalid data port, stalls upstream
// during multi-cycle accesses and registers the MEM/WB pipeline register.
module mem_stage
  import rv32_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  ex_mem_pipeline_reg_t ex_mem_i,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [31:0]          data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [31:0]          data_rdata_i,
  output logic [31:0]          mem_data_o,
  output logic                 stall_o,
  output logic                 misaligned_o,
  output mem_wb_pipeline_reg_t mem_wb_o
);

  mem_state_e           state_q, state_d;
  mem_wb_pipeline_reg_t mem_wb_q, mem_wb_d;
  logic                 active, misaligned, go, is_load, done;
  logic [31:0]          load_data;

  mem_align u_align (
    .off_i       (ex_mem_i.alu_result[1:0]),
    .size_i      (ex_mem_i.mem_size),
    .unsigned_i  (ex_mem_i.mem_unsigned),
    .rs2_i       (ex_mem_i.rs2_data),
    .rdata_i     (data_rdata_i),
    .be_o        (data_be_o),
    .wdata_o     (data_wdata_o),
    .misaligned_o(misaligned),
    .load_data_o (load_data)
  );

  assign active       = ex_mem_i.valid & (ex_mem_i.mem_read | ex_mem_i.mem_write);
  assign go           = active & ~misaligned;
  assign is_load      = ex_mem_i.mem_read;
  assign misaligned_o = active & misaligned;
  assign data_addr_o  = {ex_mem_i.alu_result[31:2], 2'b00};
  assign data_we_o    = go & ~is_load;
  assign mem_data_o   = ex_mem_i.alu_result;
  assign stall_o      = go & ~done;
  assign mem_wb_o     = mem_wb_q;

  always_comb begin
    state_d    = state_q;
    data_req_o = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE, WAIT_GNT: begin
        if (go) begin
          data_req_o = 1'b1;
          if (data_gnt_i) begin
            if (is_load) state_d = WAIT_RVALID;
            else begin
              done    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled cycle retires nothing, so WB sees a bubble.
  always_comb begin
    mem_wb_d = '0;
    if (!stall_o) begin
      mem_wb_d.alu_result = ex_mem_i.alu_result;
      mem_wb_d.load_data  = (go && is_load) ? load_data : 32'h0;
      mem_wb_d.rd_addr    = ex_mem_i.rd_addr;
      mem_wb_d.reg_write  = ex_mem_i.reg_write & ~misaligned_o;
      mem_wb_d.mem_read   = ex_mem_i.mem_read;
      mem_wb_d.valid      = ex_mem_i.valid;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule
